// File: rtl/fetch_prefetch_if.sv
// Handshake bundle shared by the fetch front end, instruction memory, decode and
// the branch-redirect source. "master" is the fetch unit's view.
interface fetch_prefetch_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_addr;

    modport master (
        output req_valid, req_addr, out_valid, out_instr, out_pc,
        input  req_ready, rsp_valid, rsp_data, out_ready, redirect_valid, redirect_addr
    );

    modport slave (
        input  req_valid, req_addr, out_valid, out_instr, out_pc,
        output req_ready, rsp_valid, rsp_data, out_ready, redirect_valid, redirect_addr
    );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end: owns the PC, issues pipelined memory requests and
// buffers in-order responses with their PC tags in a DEPTH-entry prefetch queue.
module fetch_prefetch #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst,
    fetch_prefetch_if.master bus
);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam int              AW      = $clog2(DEPTH);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   ONE_C   = CW'(1);
    localparam logic [AW-1:0]   PTR1_C  = AW'(1);
    localparam logic [XLEN-1:0] STEP_C  = XLEN'(4);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rspPc_q, rspPc_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   dropCnt_q, dropCnt_d;
    logic [AW-1:0]   rdPtr_q, rdPtr_d;
    logic [AW-1:0]   wrPtr_q, wrPtr_d;
    logic [XLEN-1:0] instrMem_q [DEPTH];
    logic [XLEN-1:0] pcMem_q [DEPTH];

    logic [CW-1:0]   count;
    logic [XLEN-1:0] redirectPc;
    logic            redirect, accept, rspDone, push, pop;

    // Credit covers queued plus in-flight instructions, so a response always has a slot.
    assign count      = occ_q + outst_q;
    assign redirect   = bus.redirect_valid;
    assign redirectPc = {bus.redirect_addr[XLEN-1:2], 2'b00};

    assign bus.req_valid = !rst && (count < DEPTH_C) && !redirect;
    assign bus.req_addr  = pc_q;
    assign bus.out_valid = (occ_q != '0);
    assign bus.out_instr = instrMem_q[rdPtr_q];
    assign bus.out_pc    = pcMem_q[rdPtr_q];

    assign accept  = bus.req_valid && bus.req_ready;
    assign rspDone = bus.rsp_valid && (outst_q != '0);
    assign push    = rspDone && (dropCnt_q == '0) && !redirect;
    assign pop     = bus.out_valid && bus.out_ready && !redirect;

    always_comb begin
        pc_d      = pc_q;
        rspPc_d   = rspPc_q;
        occ_d     = occ_q;
        dropCnt_d = dropCnt_q;
        rdPtr_d   = rdPtr_q;
        wrPtr_d   = wrPtr_q;
        outst_d   = outst_q + CW'(accept) - CW'(rspDone);

        if (redirect) begin
            // Everything still in flight after this edge belongs to the old path.
            pc_d      = redirectPc;
            rspPc_d   = redirectPc;
            occ_d     = '0;
            rdPtr_d   = '0;
            wrPtr_d   = '0;
            dropCnt_d = outst_d;
        end else begin
            if (accept) begin
                pc_d = pc_q + STEP_C;
            end
            if (rspDone && (dropCnt_q != '0)) begin
                dropCnt_d = dropCnt_q - ONE_C;
            end
            if (push) begin
                rspPc_d = rspPc_q + STEP_C;
                wrPtr_d = wrPtr_q + PTR1_C;
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR1_C;
            end
            occ_d = occ_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_ADDR;
            rspPc_q   <= RESET_ADDR;
            occ_q     <= '0;
            outst_q   <= '0;
            dropCnt_q <= '0;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instrMem_q[i] <= '0;
                pcMem_q[i]    <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            rspPc_q   <= rspPc_d;
            occ_q     <= occ_d;
            outst_q   <= outst_d;
            dropCnt_q <= dropCnt_d;
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
            if (push) begin
                instrMem_q[wrPtr_q] <= bus.rsp_data;
                pcMem_q[wrPtr_q]    <= rspPc_q;
            end
        end
    end
endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: in-order memory model, expected-instruction
// scoreboard, a per-cycle vector table for backpressure and hand-written corner cases.
`timescale 1ns/1ps
module tb_fetch_prefetch;
    localparam int          XLEN      = 32;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] WRAP_ADDR = 32'hFFFF_FFF8;

    typedef struct { logic [31:0] addr; int due; } memEntry_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } expEntry_t;
    typedef struct {
        logic        outReady;
        logic        expReqValid;
        logic [31:0] expReqAddr;
        logic        expOutValid;
        logic [31:0] expOutPc;
    } vector_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rstW = 1'b1;
    always #5 clk = ~clk;

    fetch_prefetch_if #(.XLEN(XLEN)) bif ();
    fetch_prefetch_if #(.XLEN(XLEN)) bifW ();

    fetch_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .bus(bif.master)
    );
    fetch_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_ADDR(WRAP_ADDR)) dutW (
        .clk(clk), .rst(rstW), .bus(bifW.master)
    );

    int          testsRun    = 0;
    int          testsFailed = 0;
    int          cyc         = 0;
    int          memLat      = 1;
    int          popCount    = 0;
    memEntry_t   memQ[$];
    expEntry_t   sbQ[$];
    logic [31:0] expPc;
    logic        sAccept, sRedirect, sRsp;
    logic [31:0] sAddr, sRedirAddr;
    vector_t     vecs[10];

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic outReady, input logic redir, input logic [31:0] redirAddr);
        bif.out_ready      = outReady;
        bif.redirect_valid = redir;
        bif.redirect_addr  = redirAddr;
    endtask

    // Mid-cycle: check request address against the PC model and pops against the scoreboard.
    task automatic sampleCycle();
        expEntry_t e;
        @(negedge clk);
        sAccept    = bif.req_valid && bif.req_ready;
        sRedirect  = bif.redirect_valid;
        sRedirAddr = bif.redirect_addr;
        sRsp       = bif.rsp_valid;
        sAddr      = bif.req_addr;
        if (sRedirect) begin
            checkOutput("req_valid in redirect cycle", 32'(bif.req_valid), 32'd0);
        end else if (bif.req_valid) begin
            checkOutput("req_addr", bif.req_addr, expPc);
        end
        if (bif.out_valid && bif.out_ready && !sRedirect) begin
            if (sbQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected pop: got out_pc %h, expected no valid entry", bif.out_pc);
            end else begin
                e = sbQ.pop_front();
                checkOutput("out_pc", bif.out_pc, e.pc);
                checkOutput("out_instr", bif.out_instr, e.instr);
            end
            popCount++;
        end
    endtask

    // Just after the edge: advance memory and expectation models, drive the next response.
    task automatic advanceCycle();
        @(posedge clk);
        #1;
        cyc++;
        if (sRsp && memQ.size() > 0) void'(memQ.pop_front());
        if (sAccept) memQ.push_back('{sAddr, cyc - 1 + memLat});
        if (sRedirect) begin
            sbQ.delete();
            expPc = {sRedirAddr[31:2], 2'b00};
        end else if (sAccept) begin
            sbQ.push_back('{expPc, memData(expPc)});
            expPc = expPc + 32'd4;
        end
        if (memQ.size() > 0 && memQ[0].due <= cyc) begin
            bif.rsp_valid = 1'b1;
            bif.rsp_data  = memData(memQ[0].addr);
        end else begin
            bif.rsp_valid = 1'b0;
            bif.rsp_data  = 32'h0;
        end
    endtask

    task automatic stepCycle();
        sampleCycle();
        advanceCycle();
    endtask

    task automatic stepExpectIdle(input string name);
        sampleCycle();
        checkOutput(name, 32'(bif.out_valid), 32'd0);
        advanceCycle();
    endtask

    task automatic waitPops(input int n, input int maxCycles, input string name);
        int target = popCount + n;
        int k = 0;
        while (popCount < target && k < maxCycles) begin
            stepCycle();
            k++;
        end
        testsRun++;
        if (popCount < target) begin
            testsFailed++;
            $display("[TB] FAIL %s: timed out after %0d cycles, got %0d pops, expected %0d",
                     name, maxCycles, popCount - target + n, n);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        bif.rsp_valid = 1'b0;
        bif.rsp_data  = 32'h0;
        bif.req_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        memQ.delete();
        sbQ.delete();
        expPc = 32'h0;
        cyc   = 0;
        @(posedge clk);
        #1;
        checkOutput("reset req_valid", 32'(bif.req_valid), 32'd0);
        checkOutput("reset out_valid", 32'(bif.out_valid), 32'd0);
        checkOutput("reset out_instr", bif.out_instr, 32'h0);
        checkOutput("reset out_pc", bif.out_pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] wrapReq [6];
        logic        wAcc;
        logic [31:0] wAddr;
        int          base;

        bifW.req_ready = 1'b1;
        bifW.out_ready = 1'b1;
        bifW.redirect_valid = 1'b0;
        bifW.redirect_addr  = 32'h0;
        bifW.rsp_valid = 1'b0;
        bifW.rsp_data  = 32'h0;

        // Backpressure with DEPTH=4, 1-cycle memory: fill, stall, one pop, one refill.
        vecs[0] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h4};
        vecs[8] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h4};
        vecs[9] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h4};

        memLat = 1;
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].outReady, 1'b0, 32'h0);
            sampleCycle();
            checkOutput($sformatf("vec%0d req_valid", i), 32'(bif.req_valid), 32'(vecs[i].expReqValid));
            if (vecs[i].expReqValid)
                checkOutput($sformatf("vec%0d req_addr", i), bif.req_addr, vecs[i].expReqAddr);
            checkOutput($sformatf("vec%0d out_valid", i), 32'(bif.out_valid), 32'(vecs[i].expOutValid));
            if (vecs[i].expOutValid)
                checkOutput($sformatf("vec%0d out_pc", i), bif.out_pc, vecs[i].expOutPc);
            advanceCycle();
        end

        // Streaming: one instruction per cycle from cycle 2 onward.
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0);
        base = popCount;
        for (int i = 0; i < 20; i++) stepCycle();
        checkOutput("throughput pops in 20 cycles", 32'(popCount - base), 32'd18);

        // Redirect to 0x1003 with two requests outstanding on a 3-cycle memory.
        memLat = 3;
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0);
        stepCycle();
        stepCycle();
        applyStimulus(1'b1, 1'b1, 32'h0000_1003);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        stepExpectIdle("after redirect out_valid c1");
        stepExpectIdle("after redirect out_valid c2");
        stepExpectIdle("after redirect out_valid c3");
        waitPops(1, 10, "first pop after redirect 0x1000");

        // Redirect coinciding with a response and a pop, one request outstanding.
        memLat = 1;
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) stepCycle();
        applyStimulus(1'b1, 1'b1, 32'h0000_0200);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        stepExpectIdle("same-cycle redirect out_valid c1");
        stepExpectIdle("same-cycle redirect out_valid c2");
        waitPops(1, 6, "first pop after redirect 0x200");

        // Back-to-back redirects: the second target wins.
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0);
        stepCycle();
        stepCycle();
        applyStimulus(1'b1, 1'b1, 32'h0000_0500);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 32'h0000_0600);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        waitPops(2, 8, "pops after back-to-back redirect");

        // Async reset with a full queue, then restart from the reset address.
        doReset();
        applyStimulus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) stepCycle();
        #1;
        checkOutput("full queue before reset out_valid", 32'(bif.out_valid), 32'd1);
        #1;
        rst = 1'b1;
        bif.rsp_valid = 1'b0;
        bif.rsp_data  = 32'h0;
        #1;
        checkOutput("async reset req_valid", 32'(bif.req_valid), 32'd0);
        checkOutput("async reset out_valid", 32'(bif.out_valid), 32'd0);
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0);
        waitPops(2, 8, "pops after mid-stream reset");

        // PC wrap on a second instance starting at FFFF_FFF8.
        wrapReq[0] = 32'hFFFF_FFF8;
        wrapReq[1] = 32'hFFFF_FFFC;
        wrapReq[2] = 32'h0000_0000;
        wrapReq[3] = 32'h0000_0004;
        wrapReq[4] = 32'h0000_0008;
        wrapReq[5] = 32'h0000_000C;
        @(posedge clk);
        #1;
        rstW = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("wrap req_valid", 32'(bifW.req_valid), 32'd1);
            checkOutput("wrap req_addr", bifW.req_addr, wrapReq[c]);
            if (c >= 2) begin
                checkOutput("wrap out_valid", 32'(bifW.out_valid), 32'd1);
                checkOutput("wrap out_pc", bifW.out_pc, wrapReq[c-2]);
                checkOutput("wrap out_instr", bifW.out_instr, memData(wrapReq[c-2]));
            end
            wAcc  = bifW.req_valid && bifW.req_ready;
            wAddr = bifW.req_addr;
            @(posedge clk);
            #1;
            bifW.rsp_valid = wAcc;
            bifW.rsp_data  = wAcc ? memData(wAddr) : 32'h0;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
